// File: rtl/dmem_sram_if.sv
// rtl/dmem_sram_if.sv - dmem bus between the core LSU (master) and dmem_sram (slave)
interface dmem_sram_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic                  csb_write_i;
  logic [DATA_W/8-1:0]   wmask_i;
  logic [ADDR_W-1:0]     waddr_i;
  logic [DATA_W-1:0]     din_i;
  logic                  csb_read_i;
  logic [ADDR_W-1:0]     raddr_i;
  logic [DATA_W-1:0]     dout_o;
  logic                  dout_valid_o;
  logic                  ready_o;

  modport master (
    output csb_write_i, wmask_i, waddr_i, din_i, csb_read_i, raddr_i,
    input  dout_o, dout_valid_o, ready_o
  );

  modport slave (
    input  csb_write_i, wmask_i, waddr_i, din_i, csb_read_i, raddr_i,
    output dout_o, dout_valid_o, ready_o
  );
endinterface

// File: rtl/dmem_sram.sv
// rtl/dmem_sram.sv - byte-masked data SRAM with write-first bypass, read pipeline and reset clear sweep
module dmem_sram #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  dmem_sram_if.slave  dmem
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int LANES = DATA_W / 8;

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                wr_en, rd_en;
  logic [DATA_W-1:0]   old_word, merged_word, rd_data;

  // Read pipeline: stage 0 is loaded on the issue edge, the last stage drives dout.
  logic                vld_q [READ_LATENCY];
  logic [DATA_W-1:0]   dat_q [READ_LATENCY];

  // Clear-sweep state register; reset restarts the sweep from word 0.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Sweep next-state: advance the pointer, leave CLEAR once the last word is zeroed.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == {ADDR_W{1'b1}}) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  assign wr_en = (state_q == RUN) && !dmem.csb_write_i;
  assign rd_en = (state_q == RUN) && !dmem.csb_read_i;

  // Lane merge of the incoming write over the stored word; also feeds the same-cycle bypass.
  always_comb begin
    old_word    = mem_q[dmem.waddr_i];
    merged_word = old_word;
    for (int n = 0; n < LANES; n++) begin
      if (dmem.wmask_i[n]) merged_word[8*n +: 8] = dmem.din_i[8*n +: 8];
    end
    rd_data = (wr_en && (dmem.waddr_i == dmem.raddr_i)) ? merged_word : mem_q[dmem.raddr_i];
  end

  // Storage array: zeroed by the sweep in CLEAR, byte-merged writes in RUN.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (state_q == CLEAR)  mem_q[ptr_q]         <= '0;
      else if (wr_en)        mem_q[dmem.waddr_i]  <= merged_word;
    end
  end

  // Read pipeline shift; data registers only move with a valid token so dout holds between reads.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        vld_q[i] <= 1'b0;
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= rd_en;
      if (rd_en) dat_q[0] <= rd_data;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign dmem.dout_o       = dat_q[READ_LATENCY-1];
  assign dmem.dout_valid_o = vld_q[READ_LATENCY-1];
  assign dmem.ready_o      = (state_q == RUN);
endmodule

// File: tb/tb_dmem_sram.sv
// tb/tb_dmem_sram.sv - directed vector bench for dmem_sram at read latency 1 and 3
module tb_dmem_sram;
  logic clk = 1'b0;
  logic r1, r3;
  int   n_vec  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  dmem_sram_if #(.ADDR_W(8), .DATA_W(32)) if1 ();
  dmem_sram_if #(.ADDR_W(8), .DATA_W(32)) if3 ();

  dmem_sram #(.ADDR_W(8), .DATA_W(32), .READ_LATENCY(1)) u1 (.clk_i(clk), .reset_i(r1), .dmem(if1.slave));
  dmem_sram #(.ADDR_W(8), .DATA_W(32), .READ_LATENCY(3)) u3 (.clk_i(clk), .reset_i(r3), .dmem(if3.slave));

  typedef struct {
    logic        we;
    logic [7:0]  waddr;
    logic [31:0] din;
    logic [3:0]  wmask;
    logic        re;
    logic [7:0]  raddr;
    logic        exp_valid;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t tbl [15];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr3(input logic [7:0] a, input logic [31:0] d);
    if3.waddr_i = a; if3.din_i = d; if3.wmask_i = 4'hF; if3.csb_write_i = 1'b0;
    step();
    if3.csb_write_i = 1'b1;
  endtask

  logic [31:0] exp_d3 [6];
  logic        exp_v3 [6];
  int          cnt, bad;

  initial begin
    // write-first rows: row 0 checks a write dropped during the sweep
    tbl[0]  = '{1'b0, 8'h00, 32'h0,        4'h0, 1'b1, 8'h30, 1'b1, 32'h00000000};
    tbl[1]  = '{1'b0, 8'h00, 32'h0,        4'h0, 1'b1, 8'h00, 1'b1, 32'h00000000};
    tbl[2]  = '{1'b0, 8'h00, 32'h0,        4'h0, 1'b1, 8'h7F, 1'b1, 32'h00000000};
    tbl[3]  = '{1'b0, 8'h00, 32'h0,        4'h0, 1'b1, 8'hFF, 1'b1, 32'h00000000};
    tbl[4]  = '{1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 1'b0, 8'h00, 1'b0, 32'h00000000};
    tbl[5]  = '{1'b0, 8'h00, 32'h0,        4'h0, 1'b1, 8'h10, 1'b1, 32'hDEADBEEF};
    tbl[6]  = '{1'b1, 8'h10, 32'h11223344, 4'h5, 1'b0, 8'h00, 1'b0, 32'hDEADBEEF};
    tbl[7]  = '{1'b0, 8'h00, 32'h0,        4'h0, 1'b1, 8'h10, 1'b1, 32'hDE22BE44};
    tbl[8]  = '{1'b1, 8'h20, 32'hAAAAAAAA, 4'hF, 1'b1, 8'h20, 1'b1, 32'hAAAAAAAA};
    tbl[9]  = '{1'b1, 8'h21, 32'hAAAAAAAA, 4'h1, 1'b1, 8'h21, 1'b1, 32'h000000AA};
    tbl[10] = '{1'b1, 8'h22, 32'hFFFFFFFF, 4'h0, 1'b1, 8'h22, 1'b1, 32'h00000000};
    tbl[11] = '{1'b1, 8'h40, 32'h12345678, 4'hF, 1'b1, 8'h10, 1'b1, 32'hDE22BE44};
    tbl[12] = '{1'b0, 8'h00, 32'h0,        4'h0, 1'b1, 8'h40, 1'b1, 32'h12345678};
    tbl[13] = '{1'b0, 8'h00, 32'h0,        4'h0, 1'b0, 8'h00, 1'b0, 32'h12345678};
    tbl[14] = '{1'b1, 8'h20, 32'h55000000, 4'h8, 1'b1, 8'h20, 1'b1, 32'h55AAAAAA};

    r1 = 1'b1; r3 = 1'b1;
    if1.csb_write_i = 1'b1; if1.csb_read_i = 1'b1; if1.wmask_i = '0; if1.waddr_i = '0; if1.din_i = '0; if1.raddr_i = '0;
    if3.csb_write_i = 1'b1; if3.csb_read_i = 1'b1; if3.wmask_i = '0; if3.waddr_i = '0; if3.din_i = '0; if3.raddr_i = '0;
    repeat (3) step();
    chk("reset_ready", {31'b0, if1.ready_o}, 32'd0);
    chk("reset_valid", {31'b0, if1.dout_valid_o}, 32'd0);
    chk("reset_dout", if1.dout_o, 32'd0);

    // Clear sweep: write at cycle 5 and read at cycle 7 must both be dropped.
    r1 = 1'b0; r3 = 1'b0;
    if1.waddr_i = 8'h30; if1.din_i = 32'hFFFFFFFF; if1.wmask_i = 4'hF; if1.raddr_i = 8'h30;
    cnt = 0; bad = 0;
    while (!if1.ready_o && cnt < 1000) begin
      if1.csb_write_i = (cnt == 5) ? 1'b0 : 1'b1;
      if1.csb_read_i  = (cnt == 7) ? 1'b0 : 1'b1;
      step();
      cnt++;
      if (if1.dout_valid_o || if1.dout_o != 32'd0) bad++;
    end
    if1.csb_write_i = 1'b1; if1.csb_read_i = 1'b1;
    chk("ready_low_cycles", 32'(cnt), 32'd256);
    chk("clear_no_read", 32'(bad), 32'd0);
    chk("rl3_ready", {31'b0, if3.ready_o}, 32'd1);

    for (int i = 0; i < 15; i++) begin
      if1.csb_write_i = ~tbl[i].we;  if1.waddr_i = tbl[i].waddr;
      if1.din_i = tbl[i].din;        if1.wmask_i = tbl[i].wmask;
      if1.csb_read_i = ~tbl[i].re;   if1.raddr_i = tbl[i].raddr;
      step();
      chk($sformatf("vec%0d_valid", i), {31'b0, if1.dout_valid_o}, {31'b0, tbl[i].exp_valid});
      chk($sformatf("vec%0d_dout", i), if1.dout_o, tbl[i].exp_dout);
    end
    if1.csb_write_i = 1'b1; if1.csb_read_i = 1'b1;

    // Latency 3: back-to-back reads of 1,2,3.
    wr3(8'h01, 32'd1); wr3(8'h02, 32'd2); wr3(8'h03, 32'd3);
    exp_v3 = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_d3 = '{32'd0, 32'd0, 32'd1, 32'd2, 32'd3, 32'd3};
    for (int j = 0; j < 6; j++) begin
      if (j < 3) begin
        if3.raddr_i = 8'(j + 1); if3.csb_read_i = 1'b0;
      end else begin
        if3.csb_read_i = 1'b1;
      end
      step();
      chk($sformatf("rl3_b2b%0d_valid", j), {31'b0, if3.dout_valid_o}, {31'b0, exp_v3[j]});
      chk($sformatf("rl3_b2b%0d_dout", j), if3.dout_o, exp_d3[j]);
    end

    // Data in flight is captured at issue; a later write does not alter it.
    if3.raddr_i = 8'h01; if3.csb_read_i = 1'b0;
    step();
    if3.csb_read_i = 1'b1;
    if3.waddr_i = 8'h01; if3.din_i = 32'h99; if3.wmask_i = 4'hF; if3.csb_write_i = 1'b0;
    step();
    if3.csb_write_i = 1'b1;
    chk("rl3_inflight_pending", {31'b0, if3.dout_valid_o}, 32'd0);
    step();
    chk("rl3_inflight_valid", {31'b0, if3.dout_valid_o}, 32'd1);
    chk("rl3_inflight_dout", if3.dout_o, 32'd1);
    if3.csb_read_i = 1'b0;
    step();
    if3.csb_read_i = 1'b1;
    step(); step();
    chk("rl3_after_write_dout", if3.dout_o, 32'h99);

    // Reset after the second strobe drops both reads.
    if3.raddr_i = 8'h01; if3.csb_read_i = 1'b0;
    step();
    if3.raddr_i = 8'h02;
    step();
    if3.csb_read_i = 1'b1; r3 = 1'b1;
    step();
    chk("rl3_reset_valid", {31'b0, if3.dout_valid_o}, 32'd0);
    chk("rl3_reset_dout", if3.dout_o, 32'd0);
    chk("rl3_reset_ready", {31'b0, if3.ready_o}, 32'd0);
    bad = 0;
    for (int j = 0; j < 6; j++) begin
      if (j == 1) r3 = 1'b0;
      step();
      if (if3.dout_valid_o || if3.dout_o != 32'd0) bad++;
    end
    chk("rl3_reset_no_pulse", 32'(bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
